// File: rtl/front_pipe_if.sv
// Front-end pipeline bundle between the hazard/decode logic and front_pipe_regs.
// The master side drives controls and decode operands; the slave side holds the pipeline state.
interface front_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  // Hazard-unit controls
  logic              stallF;
  logic              stallD;
  logic              flushD;
  logic              flushE;
  logic              pc_sel;

  // Fetch inputs
  logic [31:0]       PCNextF;
  logic [31:0]       InstrF;

  // Decode-stage operands
  logic [31:0]       RD1_D;
  logic [31:0]       RD2_D;
  logic [31:0]       ImmExt_D;
  logic [4:0]        Rs1_D;
  logic [4:0]        Rs2_D;
  logic [4:0]        RD_D;
  logic [1:0]        wbsel_D;
  logic              RegWrite_D;

  // Fetch and IF/ID state
  logic [31:0]       PCF;
  logic [31:0]       InstrD;
  logic [31:0]       PCD;
  logic [31:0]       PCPlus4D;
  logic              validD;

  // ID/EX state
  logic [31:0]       RD1_E;
  logic [31:0]       RD2_E;
  logic [31:0]       ImmExt_E;
  logic [31:0]       PCE;
  logic [31:0]       PCPlus4E;
  logic [4:0]        Rs1_E;
  logic [4:0]        Rs2_E;
  logic [4:0]        RD_E;
  logic [1:0]        wbsel_E;
  logic              RegWrite_E;
  logic              validE;

  // Performance counters
  logic [CNT_W-1:0]  lu_stall_cnt;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output stallF, stallD, flushD, flushE, pc_sel,
    output PCNextF, InstrF,
    output RD1_D, RD2_D, ImmExt_D, Rs1_D, Rs2_D, RD_D, wbsel_D, RegWrite_D,
    input  PCF, InstrD, PCD, PCPlus4D, validD,
    input  RD1_E, RD2_E, ImmExt_E, PCE, PCPlus4E,
    input  Rs1_E, Rs2_E, RD_E, wbsel_E, RegWrite_E, validE,
    input  lu_stall_cnt, redirect_cnt
  );

  modport slave (
    input  stallF, stallD, flushD, flushE, pc_sel,
    input  PCNextF, InstrF,
    input  RD1_D, RD2_D, ImmExt_D, Rs1_D, Rs2_D, RD_D, wbsel_D, RegWrite_D,
    output PCF, InstrD, PCD, PCPlus4D, validD,
    output RD1_E, RD2_E, ImmExt_E, PCE, PCPlus4E,
    output Rs1_E, Rs2_E, RD_E, wbsel_E, RegWrite_E, validE,
    output lu_stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/front_pipe_regs.sv
// PC, IF/ID and ID/EX registers of the RV32I front end, applying hazard-unit stall/flush.
// Define FRONT_PERF_CNT_EN to build the saturating load-use / redirect counters.
module front_pipe_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input logic        clk,
  input logic        rst,
  front_pipe_if.slave bus
);

  // Fetch PC
  logic [31:0] pc_q, pc_d;

  // IF/ID
  logic [31:0] instr_dq, instr_dd;
  logic [31:0] pc_dq, pc_dd;
  logic [31:0] pcplus4_dq, pcplus4_dd;
  logic        valid_dq, valid_dd;

  // ID/EX
  logic [31:0] rd1_eq, rd1_ed;
  logic [31:0] rd2_eq, rd2_ed;
  logic [31:0] imm_eq, imm_ed;
  logic [31:0] pc_eq, pc_ed;
  logic [31:0] pcplus4_eq, pcplus4_ed;
  logic [4:0]  rs1_eq, rs1_ed;
  logic [4:0]  rs2_eq, rs2_ed;
  logic [4:0]  rd_eq, rd_ed;
  logic [1:0]  wbsel_eq, wbsel_ed;
  logic        regwrite_eq, regwrite_ed;
  logic        valid_eq, valid_ed;

  logic [31:0] pcplus4_f;

  assign pcplus4_f = pc_q + 32'd4;

  // Redirect must win over the hold because the hazard unit drops stallF during a redirect.
  always_comb begin
    pc_d = pc_q;
    if (bus.stallF || bus.pc_sel) begin
      pc_d = bus.PCNextF;
    end
  end

  always_comb begin
    instr_dd   = instr_dq;
    pc_dd      = pc_dq;
    pcplus4_dd = pcplus4_dq;
    valid_dd   = valid_dq;
    if (bus.flushD) begin
      instr_dd   = NOP_INSTR;
      pc_dd      = 32'h0;
      pcplus4_dd = 32'h0;
      valid_dd   = 1'b0;
    end else if (bus.stallD) begin
      instr_dd   = bus.InstrF;
      pc_dd      = pc_q;
      pcplus4_dd = pcplus4_f;
      valid_dd   = 1'b1;
    end
  end

  // No hold on ID/EX: a stalled D is always paired with a flushed E.
  always_comb begin
    rd1_ed      = bus.RD1_D;
    rd2_ed      = bus.RD2_D;
    imm_ed      = bus.ImmExt_D;
    pc_ed       = pc_dq;
    pcplus4_ed  = pcplus4_dq;
    rs1_ed      = bus.Rs1_D;
    rs2_ed      = bus.Rs2_D;
    rd_ed       = bus.RD_D;
    wbsel_ed    = bus.wbsel_D;
    regwrite_ed = bus.RegWrite_D;
    valid_ed    = valid_dq;
    if (bus.flushE) begin
      rd1_ed      = 32'h0;
      rd2_ed      = 32'h0;
      imm_ed      = 32'h0;
      pc_ed       = 32'h0;
      pcplus4_ed  = 32'h0;
      rs1_ed      = 5'd0;
      rs2_ed      = 5'd0;
      rd_ed       = 5'd0;
      wbsel_ed    = 2'b00;
      regwrite_ed = 1'b0;
      valid_ed    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_dq    <= NOP_INSTR;
      pc_dq       <= 32'h0;
      pcplus4_dq  <= 32'h0;
      valid_dq    <= 1'b0;
      rd1_eq      <= 32'h0;
      rd2_eq      <= 32'h0;
      imm_eq      <= 32'h0;
      pc_eq       <= 32'h0;
      pcplus4_eq  <= 32'h0;
      rs1_eq      <= 5'd0;
      rs2_eq      <= 5'd0;
      rd_eq       <= 5'd0;
      wbsel_eq    <= 2'b00;
      regwrite_eq <= 1'b0;
      valid_eq    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_dq    <= instr_dd;
      pc_dq       <= pc_dd;
      pcplus4_dq  <= pcplus4_dd;
      valid_dq    <= valid_dd;
      rd1_eq      <= rd1_ed;
      rd2_eq      <= rd2_ed;
      imm_eq      <= imm_ed;
      pc_eq       <= pc_ed;
      pcplus4_eq  <= pcplus4_ed;
      rs1_eq      <= rs1_ed;
      rs2_eq      <= rs2_ed;
      rd_eq       <= rd_ed;
      wbsel_eq    <= wbsel_ed;
      regwrite_eq <= regwrite_ed;
      valid_eq    <= valid_ed;
    end
  end

`ifdef FRONT_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  // A flushed D is a redirect bubble, not a load-use hold, so it is not counted.
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (!bus.stallD && !bus.flushD && (lu_cnt_q != {CNT_W{1'b1}})) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
    if (bus.pc_sel && (redir_cnt_q != {CNT_W{1'b1}})) begin
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q    <= {CNT_W{1'b0}};
      redir_cnt_q <= {CNT_W{1'b0}};
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.lu_stall_cnt = lu_cnt_q;
  assign bus.redirect_cnt = redir_cnt_q;
`else
  assign bus.lu_stall_cnt = {CNT_W{1'b0}};
  assign bus.redirect_cnt = {CNT_W{1'b0}};
`endif

  assign bus.PCF        = pc_q;
  assign bus.InstrD     = instr_dq;
  assign bus.PCD        = pc_dq;
  assign bus.PCPlus4D   = pcplus4_dq;
  assign bus.validD     = valid_dq;
  assign bus.RD1_E      = rd1_eq;
  assign bus.RD2_E      = rd2_eq;
  assign bus.ImmExt_E   = imm_eq;
  assign bus.PCE        = pc_eq;
  assign bus.PCPlus4E   = pcplus4_eq;
  assign bus.Rs1_E      = rs1_eq;
  assign bus.Rs2_E      = rs2_eq;
  assign bus.RD_E       = rd_eq;
  assign bus.wbsel_E    = wbsel_eq;
  assign bus.RegWrite_E = regwrite_eq;
  assign bus.validE     = valid_eq;

endmodule

// File: tb/tb_front_pipe_regs.sv
// Scoreboard bench for front_pipe_regs: stimulus queues expected register values per edge,
// a negedge monitor pops and compares them.
module tb_front_pipe_regs;

`ifdef FRONT_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  typedef enum logic [4:0] {
    SigPCF, SigInstrD, SigPCD, SigPCPlus4D, SigValidD,
    SigRD1E, SigRD2E, SigImmE, SigPCE, SigPCPlus4E,
    SigRs1E, SigRs2E, SigRdE, SigWbselE, SigRegWriteE, SigValidE,
    SigLu, SigRedir
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  front_pipe_if #(.CNT_W(2)) bus ();

  front_pipe_regs #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0013),
    .CNT_W    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get(input sig_e s);
    case (s)
      SigPCF:       return bus.PCF;
      SigInstrD:    return bus.InstrD;
      SigPCD:       return bus.PCD;
      SigPCPlus4D:  return bus.PCPlus4D;
      SigValidD:    return {31'd0, bus.validD};
      SigRD1E:      return bus.RD1_E;
      SigRD2E:      return bus.RD2_E;
      SigImmE:      return bus.ImmExt_E;
      SigPCE:       return bus.PCE;
      SigPCPlus4E:  return bus.PCPlus4E;
      SigRs1E:      return {27'd0, bus.Rs1_E};
      SigRs2E:      return {27'd0, bus.Rs2_E};
      SigRdE:       return {27'd0, bus.RD_E};
      SigWbselE:    return {30'd0, bus.wbsel_E};
      SigRegWriteE: return {31'd0, bus.RegWrite_E};
      SigValidE:    return {31'd0, bus.validE};
      SigLu:        return {30'd0, bus.lu_stall_cnt};
      SigRedir:     return {30'd0, bus.redirect_cnt};
      default:      return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Expectation for the state right after the next rising edge.
  task automatic ex(input sig_e s, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.sig  = s;
    e.val  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic fe, input logic ps, input logic [31:0] nxt,
                       input logic [31:0] instr);
    rst         = r;
    bus.stallF  = sf;
    bus.stallD  = sd;
    bus.flushD  = fd;
    bus.flushE  = fe;
    bus.pc_sel  = ps;
    bus.PCNextF = nxt;
    bus.InstrF  = instr;
  endtask

  task automatic dec(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [1:0] wb, input logic rw);
    bus.RD1_D      = rd1;
    bus.RD2_D      = rd2;
    bus.ImmExt_D   = imm;
    bus.Rs1_D      = rs1;
    bus.Rs2_D      = rs2;
    bus.RD_D       = rd;
    bus.wbsel_D    = wb;
    bus.RegWrite_D = rw;
  endtask

  // Monitor: compares every expectation tagged with the current edge count.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        got = get(e.sig);
        n_tests++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: check missed (tag %0d, cycle %0d)", e.name, e.cyc, cyc);
        end else if (got !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %08h expected %08h (cycle %0d)", e.name, got, e.val, cyc);
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    dec(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);

    // Reset
    ex(SigPCF, 32'h100, "rst_pcf");
    ex(SigInstrD, 32'h13, "rst_instrd");
    ex(SigValidD, 0, "rst_validd");
    ex(SigPCD, 0, "rst_pcd");
    ex(SigValidE, 0, "rst_valide");
    ex(SigRdE, 0, "rst_rde");
    ex(SigPCE, 0, "rst_pce");
    ex(SigRegWriteE, 0, "rst_regwre");
    ex(SigWbselE, 0, "rst_wbsele");
    ex(SigLu, 0, "rst_lu");
    ex(SigRedir, 0, "rst_redir");
    @(negedge clk);

    // Free run: first instruction into D
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0050_0093);
    dec(32'hAAAA_0001, 32'hBBBB_0002, 32'h5, 5'd3, 5'd4, 5'd5, 2'b01, 1'b1);
    ex(SigPCF, 32'h104, "run1_pcf");
    ex(SigInstrD, 32'h0050_0093, "run1_instrd");
    ex(SigPCD, 32'h100, "run1_pcd");
    ex(SigPCPlus4D, 32'h104, "run1_pcp4d");
    ex(SigValidD, 1, "run1_validd");
    ex(SigValidE, 0, "run1_valide");
    ex(SigRD1E, 32'hAAAA_0001, "run1_rd1e");
    ex(SigRD2E, 32'hBBBB_0002, "run1_rd2e");
    ex(SigImmE, 32'h5, "run1_imme");
    ex(SigRs1E, 3, "run1_rs1e");
    ex(SigRs2E, 4, "run1_rs2e");
    ex(SigRdE, 5, "run1_rde");
    ex(SigWbselE, 1, "run1_wbsele");
    @(negedge clk);

    // Free run: load enters E
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h00A0_0113);
    dec(32'h11, 32'h22, 32'hFFFF_FFF0, 5'd0, 5'd0, 5'd1, 2'b11, 1'b1);
    ex(SigPCF, 32'h108, "run2_pcf");
    ex(SigInstrD, 32'h00A0_0113, "run2_instrd");
    ex(SigPCD, 32'h104, "run2_pcd");
    ex(SigValidE, 1, "run2_valide");
    ex(SigPCE, 32'h100, "run2_pce");
    ex(SigPCPlus4E, 32'h104, "run2_pcp4e");
    ex(SigWbselE, 3, "run2_wbsele");
    ex(SigRdE, 1, "run2_rde");
    ex(SigImmE, 32'hFFFF_FFF0, "run2_imme");
    @(negedge clk);

    // Load-use stall
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10C, 32'hDEAD_BEEF);
    ex(SigPCF, 32'h108, "lu_pcf_hold");
    ex(SigInstrD, 32'h00A0_0113, "lu_instrd_hold");
    ex(SigPCD, 32'h104, "lu_pcd_hold");
    ex(SigValidD, 1, "lu_validd");
    ex(SigRdE, 0, "lu_rde");
    ex(SigRegWriteE, 0, "lu_regwre");
    ex(SigValidE, 0, "lu_valide");
    ex(SigWbselE, 0, "lu_wbsele");
    ex(SigPCE, 0, "lu_pce");
    ex(SigLu, Perf ? 32'd1 : 32'd0, "lu_cnt1");
    ex(SigRedir, 0, "lu_redir");
    @(negedge clk);

    // Held instruction proceeds into E
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10C, 32'h0020_8193);
    dec(32'h33, 32'h44, 32'h8, 5'd1, 5'd0, 5'd2, 2'b00, 1'b1);
    ex(SigPCF, 32'h10C, "rel_pcf");
    ex(SigInstrD, 32'h0020_8193, "rel_instrd");
    ex(SigPCD, 32'h108, "rel_pcd");
    ex(SigPCPlus4D, 32'h10C, "rel_pcp4d");
    ex(SigValidE, 1, "rel_valide");
    ex(SigPCE, 32'h104, "rel_pce");
    ex(SigPCPlus4E, 32'h108, "rel_pcp4e");
    ex(SigRdE, 2, "rel_rde");
    ex(SigRs1E, 1, "rel_rs1e");
    ex(SigRD1E, 32'h33, "rel_rd1e");
    ex(SigLu, Perf ? 32'd1 : 32'd0, "rel_lu");
    @(negedge clk);

    // Redirect, with stallD=0 alongside flushD to show flush priority
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    ex(SigPCF, 32'h200, "redir_pcf");
    ex(SigInstrD, 32'h13, "redir_instrd");
    ex(SigValidD, 0, "redir_validd");
    ex(SigPCD, 0, "redir_pcd");
    ex(SigPCPlus4D, 0, "redir_pcp4d");
    ex(SigValidE, 0, "redir_valide");
    ex(SigRdE, 0, "redir_rde");
    ex(SigRegWriteE, 0, "redir_regwre");
    ex(SigRedir, Perf ? 32'd1 : 32'd0, "redir_cnt1");
    ex(SigLu, Perf ? 32'd1 : 32'd0, "redir_lu");
    @(negedge clk);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h1111_1111);
    ex(SigPCF, 32'h204, "tgt_pcf");
    ex(SigInstrD, 32'h1111_1111, "tgt_instrd");
    ex(SigPCD, 32'h200, "tgt_pcd");
    ex(SigPCPlus4D, 32'h204, "tgt_pcp4d");
    ex(SigValidE, 0, "tgt_valide");
    @(negedge clk);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h2222_2222);
    ex(SigPCF, 32'hFFFF_FFFC, "top_pcf");
    ex(SigPCD, 32'h204, "top_pcd");
    ex(SigValidE, 1, "top_valide");
    ex(SigPCE, 32'h200, "top_pce");
    @(negedge clk);

    // PC+4 wraps at the top of the address space
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
    ex(SigPCF, 32'h0, "wrap_pcf");
    ex(SigPCD, 32'hFFFF_FFFC, "wrap_pcd");
    ex(SigPCPlus4D, 32'h0, "wrap_pcp4d");
    ex(SigInstrD, 32'h3333_3333, "wrap_instrd");
    @(negedge clk);

    // Five stall cycles saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h4444_4444);
      ex(SigPCF, 32'h0, "sat_pcf");
      ex(SigInstrD, 32'h3333_3333, "sat_instrd");
      ex(SigValidE, 0, "sat_valide");
      ex(SigLu, Perf ? ((i == 0) ? 32'd2 : 32'd3) : 32'd0, "sat_lu");
      @(negedge clk);
    end

    // Reset during a held load-use overrides stall, flush and redirect
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h4444_4444);
    ex(SigPCF, 32'h100, "mrst_pcf");
    ex(SigInstrD, 32'h13, "mrst_instrd");
    ex(SigValidD, 0, "mrst_validd");
    ex(SigPCD, 0, "mrst_pcd");
    ex(SigValidE, 0, "mrst_valide");
    ex(SigRdE, 0, "mrst_rde");
    ex(SigLu, 0, "mrst_lu");
    ex(SigRedir, 0, "mrst_redir");
    @(negedge clk);

    // PC held (stallF=0) while D still loads
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h5555_5555);
    ex(SigPCF, 32'h100, "pchold_pcf");
    ex(SigInstrD, 32'h5555_5555, "pchold_instrd");
    ex(SigPCD, 32'h100, "pchold_pcd");
    ex(SigValidD, 1, "pchold_validd");
    ex(SigLu, 0, "pchold_lu");
    @(negedge clk);

    repeat (2) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked (tag %0d)", e.name, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/front_pipe_regs.md
# front_pipe_regs

Pipeline state holder for the fetch, decode and execute front end of the 5-stage RV32I core. It owns the PC register, the IF/ID register and the ID/EX register. It is the consumer of the hazard unit's stall/flush outputs and applies them to the architectural pipeline state. It also presents to the hazard unit and forwarding muxes the `Rs1_E`/`Rs2_E`/`RD_E`/`wbsel_E` fields those blocks compare against. Optional saturating counters record load-use stall cycles and redirect flushes.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded by reset.
- `NOP_INSTR`, 32'h0000_0013: bubble instruction (addi x0,x0,0) inserted into IF/ID on flush.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `stallF`  in  1: active-low PC enable; 1 = advance, 0 = hold.
- `stallD`  in  1: active-low IF/ID enable; 1 = advance, 0 = hold.
- `flushD`  in  1: clear IF/ID to bubble.
- `flushE`  in  1: clear ID/EX to bubble.
- `pc_sel`  in  1: branch/jump redirect taken in EX.
- `PCNextF`  in  32: next-PC mux output (target when `pc_sel`=1).
- `InstrF`  in  32: instruction memory read data.
- `RD1_D`, `RD2_D`, `ImmExt_D`  in  32 each: decode-stage operands.
- `Rs1_D`, `Rs2_D`, `RD_D`  in  5 each: decode register indices.
- `wbsel_D`  in  2: writeback select; 2'b11 = load.
- `RegWrite_D`  in  1: decode register-write enable.
- `PCF`  out  32: current fetch PC.
- `InstrD`, `PCD`, `PCPlus4D`  out  32 each: IF/ID contents.
- `validD`  out  1: IF/ID holds a real instruction.
- `RD1_E`, `RD2_E`, `ImmExt_E`, `PCE`, `PCPlus4E`  out  32 each: ID/EX data.
- `Rs1_E`, `Rs2_E`, `RD_E`  out  5 each: ID/EX indices.
- `wbsel_E`  out  2: ID/EX writeback select.
- `RegWrite_E`, `validE`  out  1 each: ID/EX control.
- `lu_stall_cnt`, `redirect_cnt`  out  `CNT_W` each: performance counters (see Configuration).

## Operation
- PC register: loads `PCNextF` when `stallF`=1 or `pc_sel`=1. The redirect overrides the hold, because the hazard unit drives `stallF`=0 during a redirect. Otherwise `PCF` holds.
- IF/ID priority, highest first:
  - `flushD`: `InstrD`=`NOP_INSTR`, `validD`=0, `PCD`/`PCPlus4D`=0.
  - `stallD`=0: hold.
  - else: load `InstrF`, `PCF`, `PCF`+4 and set `validD`=1.
- `PCPlus4D` is a 32-bit add of `PCF`+4 and wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- ID/EX priority, highest first:
  - `flushE`: all ID/EX outputs = 0, including `Rs1_E`/`Rs2_E`/`RD_E` (x0) and `wbsel_E`=2'b00. The bubble therefore never matches a forwarding or load-use compare.
  - else: load all decode inputs; `validE`=`validD`.
  - ID/EX has no stall; the hazard unit always flushes E when it stalls D.
- Combination `stallD`=0 with `flushD`=1: flush wins.
- Combination `flushE`=1 with `flushD`=1: both stages bubble in the same cycle.

## Timing
- All outputs are registered. Latency is 1 cycle: IF→D, D→E.
- On the first edge with `rst`=1: `PCF`=`RESET_PC`; every other output = 0, except `InstrD`=`NOP_INSTR`. `rst` overrides stall/flush/pc_sel.
- Reset asserted mid-operation discards in-flight D/E contents on that edge.
- Load-use: cycle N has `stallF`=`stallD`=0 and `flushE`=1. At edge N+1, `PCF` and the IF/ID register are unchanged and E holds a bubble. At edge N+2 the held instruction enters E.
- Redirect: cycle N has `pc_sel`=1 and `flushD`=`flushE`=1. At edge N+1, `PCF`=target and both D and E hold bubbles.

## Configuration
- `FRONT_PERF_CNT_EN` defined:
  - `lu_stall_cnt` increments on each edge with `stallD`=0, `flushD`=0 and `rst`=0.
  - `redirect_cnt` increments on each edge with `pc_sel`=1 and `rst`=0.
  - Both counters saturate at 2^`CNT_W`−1 and are cleared by `rst`.
- `FRONT_PERF_CNT_EN` undefined: no counter flops are built and both outputs are tied to 0.

## Test plan
- Reset, `RESET_PC`=32'h100 → after the edge: `PCF`=32'h100, `InstrD`=32'h13, `validD`=`validE`=0, all E outputs 0.
- Free run, `stallF`=`stallD`=1, `PCNextF`=`PCF`+4, `InstrF`=32'h00500093 at `PCF`=32'h100 → one edge later `InstrD`=32'h00500093, `PCD`=32'h100, `PCPlus4D`=32'h104; one edge after that `validE`=1.
- Load-use: `stallF`=`stallD`=0, `flushE`=1 for 1 cycle while `PCF`=32'h108 → `PCF` stays 32'h108, `InstrD` held, `RD_E`=0, `RegWrite_E`=0; the next edge loads the held instruction into E. With the macro, `lu_stall_cnt`=1.
- Redirect: `pc_sel`=1, `PCNextF`=32'h200, `stallF`=0, `flushD`=`flushE`=1 → `PCF`=32'h200, `InstrD`=32'h13, `validD`=`validE`=0. With the macro, `redirect_cnt`=1.
- Priority/boundary: `stallD`=0 and `flushD`=1 together → D bubbled. `PCF`=32'hFFFF_FFFC → `PCPlus4D`=0. `CNT_W`=2 with 5 stall cycles → `lu_stall_cnt`=3.
- Mid-stall reset: `rst`=1 during a held load-use → `PCF`=`RESET_PC`, all counters 0, D/E bubbles.
